// File: rtl/pio_input_pkg.sv
// Shared constants for the PIO input port: register map and synchronizer/filter depths.
// Optional glitch filter is selected with the PIO_INPUT_GLITCH_FILTER_EN macro.
package pio_input_pkg;

    typedef enum logic [1:0] {
        ADDR_PIN     = 2'd0,
        ADDR_PEND    = 2'd1,
        ADDR_RISE_EN = 2'd2,
        ADDR_FALL_EN = 2'd3
    } reg_addr_e;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 3;

    // Cycles after reset release before prev holds a genuinely sampled PIN value.
`ifdef PIO_INPUT_GLITCH_FILTER_EN
    localparam int DET_STAGES = SYNC_STAGES + FILTER_LEN - 1;
`else
    localparam int DET_STAGES = SYNC_STAGES;
`endif

endpackage

// File: rtl/pio_input_sync.sv
// Per-vector 2-flop synchronizer, optional stability filter, and rise/fall detection.
// Filter is built only when PIO_INPUT_GLITCH_FILTER_EN is defined.
module pio_input_sync
    import pio_input_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev;
    logic [DET_STAGES:0]               vld_pipe;
    logic                              det_en;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q   <= '0;
            prev     <= '0;
            vld_pipe <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pins};
            prev     <= pin;
            vld_pipe <= {vld_pipe[DET_STAGES-1:0], 1'b1};
        end
    end

`ifdef PIO_INPUT_GLITCH_FILTER_EN
    logic [FILTER_LEN-2:0][WIDTH-1:0] hist;
    logic [WIDTH-1:0]                 held;
    logic [WIDTH-1:0]                 stable;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hist <= '0;
            held <= '0;
        end else begin
            hist <= {hist[FILTER_LEN-3:0], sync_q[SYNC_STAGES-1]};
            held <= pin;
        end
    end

    // A bit follows the synchronizer only once its last FILTER_LEN samples agree.
    always_comb begin
        stable = '1;
        for (int k = 0; k < FILTER_LEN - 1; k++)
            stable &= ~(sync_q[SYNC_STAGES-1] ^ hist[k]);
        pin = (stable & sync_q[SYNC_STAGES-1]) | (~stable & held);
    end
`else
    assign pin = sync_q[SYNC_STAGES-1];
`endif

    // Edges stay masked until the whole pipe, prev included, has refilled after reset.
    assign det_en = vld_pipe[DET_STAGES];
    assign rise   =  pin & ~prev & {WIDTH{det_en}};
    assign fall   = ~pin &  prev & {WIDTH{det_en}};

endmodule

// File: rtl/pio_input_port.sv
// PIO input port: edge-triggered pending register with W1C clear, enables and irq encoder.
// PIO_INPUT_GLITCH_FILTER_EN adds a 3-sample glitch filter inside pio_input_sync.
module pio_input_port
    import pio_input_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         pins,
    input  logic [1:0]               addr,
    input  logic                     read_enable,
    input  logic                     write_enable,
    input  logic [WIDTH-1:0]         d,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic                     irq,
    output logic [$clog2(WIDTH)-1:0] irq_vector
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] pin, rise, fall;
    logic [WIDTH-1:0] pend, rise_en, fall_en;
    logic [WIDTH-1:0] pend_set, pend_clr, rd_data;

    pio_input_sync #(.WIDTH(WIDTH)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .pins    (pins),
        .pin     (pin),
        .rise    (rise),
        .fall    (fall)
    );

    // Enables are sampled before any same-cycle write lands, so the old mask applies.
    assign pend_set = (rise & rise_en) | (fall & fall_en);
    assign pend_clr = (write_enable && addr == ADDR_PEND) ? d : '0;

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_PIN:     rd_data = pin;
            ADDR_PEND:    rd_data = pend;
            ADDR_RISE_EN: rd_data = rise_en;
            ADDR_FALL_EN: rd_data = fall_en;
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pend    <= '0;
            rise_en <= '0;
            fall_en <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            // Set is OR-ed after the clear so a new edge survives a colliding W1C.
            pend    <= (pend & ~pend_clr) | pend_set;
            q_valid <= read_enable;
            if (read_enable)
                q <= rd_data;
            if (write_enable && addr == ADDR_RISE_EN)
                rise_en <= d;
            if (write_enable && addr == ADDR_FALL_EN)
                fall_en <= d;
        end
    end

    assign irq = |pend;

    always_comb begin
        irq_vector = '0;
        for (int i = 0; i < WIDTH; i++)
            if (pend[i])
                irq_vector = IDX_W'(i);
    end

endmodule
